multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle control FSM that fetches a 16-bit instruction, latches it in the instruction register (IR) and decodes it.
- Sequences fetch/decode/execute/memory/writeback for the datapath.
- Drives the opcode/opext fields straight into the ALU-control decoder downstream.
- Issues the register-file, memory, PC and flag strobes for every instruction class.

Parameters:
MEM_WAIT_MAX, 255, max cycles any memory access may wait for mem_ready before abort (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr  input  16  memory read data; captured into IR at end of fetch
mem_ready  input  1  memory handshake: current read/write completes this cycle
flags  input  5  {C,L,F,Z,N} from the flag register
opcode  output  4  IR[15:12], to ALU control
opext  output  4  IR[7:4], to ALU control
rdest  output  4  IR[11:8]; also the branch condition code
rsrc  output  4  IR[3:0]
imm  output  8  IR[7:0]
ir_write  output  1  IR load strobe
mem_read  output  1  memory read request
mem_write  output  1  memory write request
addr_sel  output  1  0 = PC drives memory address, 1 = Rsrc register
alu_src_imm  output  1  ALU B operand = imm (1) or Rsrc (0)
wb_sel  output  1  register writeback from ALU (0) or memory (1)
reg_write  output  1  register file write strobe
flag_write  output  1  flag register write strobe
pc_en  output  1  PC update strobe
pc_src  output  2  0 = PC+1, 1 = PC+sext(imm), 2 = Rsrc
mem_timeout  output  1  sticky: memory wait exceeded MEM_WAIT_MAX

Behaviour:
- Reset:
  - state = FETCH; IR = 16'h0000; wait counter = 0; mem_timeout = 0.
  - While reset is high, every strobe and every select output is forced to 0.
- Field outputs (opcode, opext, rdest, rsrc, imm) are combinational slices of IR. IR changes only on an ir_write cycle.
- All other outputs are Moore functions of state, IR and flags.
- FETCH:
  - mem_read=1, addr_sel=0.
  - When mem_ready=1: ir_write=1, go to DECODE. Otherwise stay.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 0000 → EXEC_R.
  - 0101, 1001, 0001, 0011, 0010, 1011, 1101, 0110, 1111 → EXEC_I.
  - 1000 → EXEC_R if opext=0100, else EXEC_I.
  - 0100 with opext 0000 → LOAD; opext 0100 → STORE; opext 1100 → JUMP.
  - 1100 → BRANCH.
  - Anything else → ILLEGAL.
- EXEC_R / EXEC_I:
  - alu_src_imm = 0 for EXEC_R, 1 for EXEC_I.
  - reg_write=1, except compare (opcode 1011, or opcode 0000 with opext 1011).
  - flag_write=1 for add, sub and compare (opcode or R-type opext in {0101, 1001, 1011}).
  - pc_en=1, pc_src=0; next state FETCH.
- LOAD:
  - mem_read=1, addr_sel=1.
  - On mem_ready go to LOAD_WB.
- LOAD_WB: reg_write=1, wb_sel=1, pc_en=1, pc_src=0 → FETCH.
- STORE:
  - mem_write=1, addr_sel=1.
  - On mem_ready: pc_en=1, pc_src=0 → FETCH.
- BRANCH / JUMP:
  - Condition code = rdest.
    - EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C.
    - GT 0110: N. LE 0111: !N. FS 1000: F. FC 1001: !F.
    - LO 1010: L. HS 1011: !L.
    - UC 1110: always. Any other code: never.
  - pc_en=1. pc_src = (1 for BRANCH / 2 for JUMP) if the condition is true, else 0. Next state FETCH.
- ILLEGAL: pc_en=1, pc_src=0 → FETCH (NOP semantics).
- Wait counter:
  - Increments each cycle the FSM sits in FETCH, LOAD or STORE with mem_ready=0.
  - Clears on mem_ready and on any state change.
  - Timeout: if the counter reaches MEM_WAIT_MAX with mem_ready still 0:
    - set mem_timeout (cleared only by reset) and drop the request;
    - from LOAD/STORE: pc_en=1, pc_src=0 → FETCH;
    - from FETCH: no pc_en, stay in FETCH (refetch).
- mem_ready is ignored in every state without an active request.
- Reset mid-instruction: returns to FETCH next edge. No write strobe may assert in the cycle following reset deassertion.
- Cycle counts with zero-wait memory: ALU/branch/jump/illegal 3, store 3, load 4.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- When defined:
  - an extra output `illegal`, 1 bit, is added;
  - ILLEGAL state sets sticky illegal=1 and enters HALT;
  - HALT asserts no strobes (no mem_read) until reset, and reset clears illegal.
- When undefined: the port is absent and ILLEGAL behaves as a NOP as described above.

Test Plan:
- Reset then instr=16'h0152 (add R1,R2) with mem_ready=1 → ir_write in cycle 1; cycle 3 shows opcode=0, opext=5, reg_write=1, flag_write=1, pc_en=1, pc_src=0.
- instr=16'h4203 (load R2,[R3]), mem_ready low 3 cycles in LOAD → mem_read and addr_sel high throughout; LOAD_WB shows reg_write=1, wb_sel=1; 7 cycles total.
- instr=16'hC0F6 (BEQ -10) with flags Z=1 → pc_en=1, pc_src=1; repeat with Z=0 → pc_src=0.
- instr=16'hB3A5 (cmpi) → flag_write=1, reg_write=0, alu_src_imm=1.
- MEM_WAIT_MAX=4, mem_ready held 0 in STORE → after 4 wait cycles mem_timeout=1, mem_write drops, pc_en pulses, FSM returns to FETCH.
- instr=16'h7000 (illegal) → NOP pc_en pulse without ILLEGAL_TRAP_EN; with the macro, illegal=1 and all strobes stay 0 until reset.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle fetch/decode/execute control FSM
//
// Purpose: fetches a 16-bit instruction into IR, decodes it and sequences
// execute / memory / writeback, issuing register-file, memory, PC and flag
// strobes for each instruction class. Memory waits are bounded by
// MEM_WAIT_MAX; an expired wait sets the sticky mem_timeout flag.
//
// Optional feature macro: ILLEGAL_TRAP_EN (adds output 'illegal'; an illegal
// opcode halts the FSM until reset instead of acting as a NOP).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   instr[15:0]        memory read data, captured into IR at end of fetch
//   mem_ready          memory access completes this cycle
//   flags[4:0]         {C,L,F,Z,N}
//   opcode/opext/rdest/rsrc/imm   combinational slices of IR
//   ir_write, mem_read, mem_write, addr_sel, alu_src_imm, wb_sel,
//   reg_write, flag_write, pc_en, pc_src[1:0]   datapath strobes/selects
//   mem_timeout        sticky memory-wait abort flag
//   illegal            sticky illegal-opcode flag (ILLEGAL_TRAP_EN only)
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic [4:0]  flags,
  output logic [3:0]  opcode,
  output logic [3:0]  opext,
  output logic [3:0]  rdest,
  output logic [3:0]  rsrc,
  output logic [7:0]  imm,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        alu_src_imm,
  output logic        wb_sel,
  output logic        reg_write,
  output logic        flag_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        mem_timeout
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_LOAD    = 4'd4,
    S_LOAD_WB = 4'd5,
    S_STORE   = 4'd6,
    S_BRANCH  = 4'd7,
    S_JUMP    = 4'd8,
    S_ILLEGAL = 4'd9,
    S_HALT    = 4'd10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [7:0]  wait_q;
  logic        mem_timeout_q;
  logic        wait_st, timeout, fetch_done;
  logic        is_cmp, is_flag_op, cond_true;

  assign opcode = ir_q[15:12];
  assign rdest  = ir_q[11:8];
  assign opext  = ir_q[7:4];
  assign rsrc   = ir_q[3:0];
  assign imm    = ir_q[7:0];

  // Only these states carry an outstanding memory request.
  assign wait_st    = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);
  assign timeout    = wait_st && !mem_ready && (wait_q == 8'(MEM_WAIT_MAX));
  assign fetch_done = (state_q == S_FETCH) && mem_ready;

  // Compare updates flags but never writes a register; add/sub/compare are
  // identified by opcode for I-type and by opext for R-type (opcode 0000).
  assign is_cmp     = (opcode == 4'b1011) || ((opcode == 4'b0000) && (opext == 4'b1011));
  assign is_flag_op = (opcode inside {4'b0101, 4'b1001, 4'b1011}) ||
                      ((opcode == 4'b0000) && (opext inside {4'b0101, 4'b1001, 4'b1011}));

  // flags = {C,L,F,Z,N}; rdest doubles as the condition code.
  always_comb begin
    cond_true = 1'b0;
    case (rdest)
      4'b0000: cond_true = flags[1];
      4'b0001: cond_true = !flags[1];
      4'b0010: cond_true = flags[4];
      4'b0011: cond_true = !flags[4];
      4'b0110: cond_true = flags[0];
      4'b0111: cond_true = !flags[0];
      4'b1000: cond_true = flags[2];
      4'b1001: cond_true = !flags[2];
      4'b1010: cond_true = flags[3];
      4'b1011: cond_true = !flags[3];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // State register, IR, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      ir_q          <= 16'h0000;
      wait_q        <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_done) ir_q <= instr;
      // A fetch timeout stays in FETCH, so the counter must also clear on
      // timeout, not only on a state change.
      if (!wait_st || mem_ready || timeout || (state_d != state_q)) wait_q <= 8'd0;
      else wait_q <= wait_q + 8'd1;
      if (timeout) mem_timeout_q <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (state_q == S_ILLEGAL) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q && !reset;
`endif

  assign mem_timeout = mem_timeout_q && !reset;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0000: state_d = S_EXEC_R;
          4'b0101, 4'b1001, 4'b0001, 4'b0011, 4'b0010,
          4'b1011, 4'b1101, 4'b0110, 4'b1111: state_d = S_EXEC_I;
          4'b1000: state_d = (opext == 4'b0100) ? S_EXEC_R : S_EXEC_I;
          4'b0100: begin
            case (opext)
              4'b0000: state_d = S_LOAD;
              4'b0100: state_d = S_STORE;
              4'b1100: state_d = S_JUMP;
              default: state_d = S_ILLEGAL;
            endcase
          end
          4'b1100: state_d = S_BRANCH;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_LOAD: begin
        if (mem_ready)    state_d = S_LOAD_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_STORE:  if (mem_ready || timeout) state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_HALT;
      S_HALT:    state_d = S_HALT;
`else
      S_ILLEGAL: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic; reset overrides every strobe and select.
  always_comb begin
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    reg_write   = 1'b0;
    flag_write  = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read = !timeout;
        ir_write = mem_ready;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_imm = (state_q == S_EXEC_I);
        reg_write   = !is_cmp;
        flag_write  = is_flag_op;
        pc_en       = 1'b1;
      end
      S_LOAD: begin
        mem_read = !timeout;
        addr_sel = 1'b1;
        pc_en    = timeout;
      end
      S_LOAD_WB: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        pc_en     = 1'b1;
      end
      S_STORE: begin
        mem_write = !timeout;
        addr_sel  = 1'b1;
        pc_en     = mem_ready || timeout;
      end
      S_BRANCH: begin
        pc_en  = 1'b1;
        pc_src = cond_true ? 2'd1 : 2'd0;
      end
      S_JUMP: begin
        pc_en  = 1'b1;
        pc_src = cond_true ? 2'd2 : 2'd0;
      end
`ifndef ILLEGAL_TRAP_EN
      S_ILLEGAL: pc_en = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = 1'b0;
      alu_src_imm = 1'b0;
      wb_sel      = 1'b0;
      reg_write   = 1'b0;
      flag_write  = 1'b0;
      pc_en       = 1'b0;
      pc_src      = 2'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic [4:0]  flags;
  logic [3:0]  opcode, opext, rdest, rsrc;
  logic [7:0]  imm;
  logic        ir_write, mem_read, mem_write, addr_sel, alu_src_imm, wb_sel;
  logic        reg_write, flag_write, pc_en, mem_timeout;
  logic [1:0]  pc_src;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  multicycle_controller #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .flags(flags),
    .opcode(opcode), .opext(opext), .rdest(rdest), .rsrc(rsrc), .imm(imm),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .addr_sel(addr_sel), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
    .reg_write(reg_write), .flag_write(flag_write), .pc_en(pc_en),
    .pc_src(pc_src), .mem_timeout(mem_timeout)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v;
    logic [15:0] ir;
    logic        ill;
    string       tag;
  } exp_t;

  typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_JP, C_ILL} cls_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        tb_timeout = 1'b0;
  logic        tb_ill = 1'b0;
  logic [15:0] tb_ir = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected strobe vector: {irw,mrd,mwr,asel,aimm,wbs,rw,fw,pce,pcs[1:0],mto}
  function automatic logic [11:0] vec(input logic irw, mrd, mwr, asel, aimm, wbs,
                                      rw, fw, pce, input logic [1:0] pcs);
    return {irw, mrd, mwr, asel, aimm, wbs, rw, fw, pce, pcs, tb_timeout};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, {ir_write, mem_read, mem_write, addr_sel, alu_src_imm, wb_sel,
                  reg_write, flag_write, pc_en, pc_src, mem_timeout}, e.v);
      chk({e.tag, ".ir"}, {opcode, rdest, opext, rsrc}, e.ir);
      chk({e.tag, ".imm"}, imm, e.ir[7:0]);
`ifdef ILLEGAL_TRAP_EN
      chk({e.tag, ".illegal"}, illegal, e.ill);
`endif
    end
  end

  task automatic tick(input logic [11:0] v, input string tag);
    exp_t e;
    e.v = v; e.ir = tb_ir; e.ill = reset ? 1'b0 : tb_ill; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic cls_t classify(input logic [15:0] i);
    logic [3:0] op, ext;
    op = i[15:12]; ext = i[7:4];
    if (op == 4'h0) return C_R;
    if (op == 4'h8) return (ext == 4'h4) ? C_R : C_I;
    if (op == 4'hC) return C_BR;
    if (op == 4'h4) begin
      if (ext == 4'h0) return C_LD;
      if (ext == 4'h4) return C_ST;
      if (ext == 4'hC) return C_JP;
      return C_ILL;
    end
    if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'hF}) return C_I;
    return C_ILL;
  endfunction

  function automatic logic cond(input logic [3:0] cc, input logic [4:0] f);
    logic c, l, ff, z, n;
    {c, l, ff, z, n} = f;
    case (cc)
      4'h0: return z;   4'h1: return !z;
      4'h2: return c;   4'h3: return !c;
      4'h6: return n;   4'h7: return !n;
      4'h8: return ff;  4'h9: return !ff;
      4'hA: return l;   4'hB: return !l;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_fetch(input string nm, input logic [15:0] ins, input int waits);
    int cnt = 0;
    instr = ins;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      if (cnt == MAXW) begin
        tick(vec(0,0,0,0,0,0,0,0,0,2'd0), {nm, ".fetch_to"});
        tb_timeout = 1'b1;
        cnt = 0;
      end else begin
        tick(vec(0,1,0,0,0,0,0,0,0,2'd0), {nm, ".fetch_wait"});
        cnt++;
      end
    end
    mem_ready = 1'b1;
    tick(vec(1,1,0,0,0,0,0,0,0,2'd0), {nm, ".fetch"});
    tb_ir = ins;
  endtask

  // Memory phase for load/store; returns 1 if the access completed.
  task automatic do_mem(input string nm, input logic is_st, input int waits, output logic done);
    int cnt = 0;
    done = 1'b1;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      if (cnt == MAXW) begin
        tick(vec(0,0,0,1,0,0,0,0,1,2'd0), {nm, ".mem_to"});
        tb_timeout = 1'b1;
        done = 1'b0;
        break;
      end
      tick(vec(0,!is_st,is_st,1,0,0,0,0,0,2'd0), {nm, ".mem_wait"});
      cnt++;
    end
    if (done) begin
      mem_ready = 1'b1;
      tick(vec(0,!is_st,is_st,1,0,0,0,0,is_st,2'd0), {nm, ".mem"});
    end
  endtask

  task automatic run_instr(input string nm, input logic [15:0] ins, input logic [4:0] fl,
                           input int fwait, input int mwait);
    cls_t       k;
    logic [3:0] op, ext, key;
    logic       done, cmp, fw;
    flags = fl;
    do_fetch(nm, ins, fwait);
    mem_ready = 1'($urandom_range(0, 1));
    tick(12'(0) | vec(0,0,0,0,0,0,0,0,0,2'd0), {nm, ".decode"});
    k = classify(ins);
    op = ins[15:12]; ext = ins[7:4];
    key = (op == 4'h0) ? ext : op;
    cmp = (key == 4'hB);
    fw  = (key == 4'h5) || (key == 4'h9) || (key == 4'hB);
    mem_ready = 1'($urandom_range(0, 1));
    case (k)
      C_R, C_I: tick(vec(0,0,0,0,(k == C_I),0,!cmp,fw,1,2'd0), {nm, ".exec"});
      C_LD: begin
        do_mem(nm, 1'b0, mwait, done);
        if (done) begin
          mem_ready = 1'($urandom_range(0, 1));
          tick(vec(0,0,0,0,0,1,1,0,1,2'd0), {nm, ".load_wb"});
        end
      end
      C_ST: do_mem(nm, 1'b1, mwait, done);
      C_BR: tick(vec(0,0,0,0,0,0,0,0,1,cond(ins[11:8], fl) ? 2'd1 : 2'd0), {nm, ".branch"});
      C_JP: tick(vec(0,0,0,0,0,0,0,0,1,cond(ins[11:8], fl) ? 2'd2 : 2'd0), {nm, ".jump"});
      default: begin
`ifdef ILLEGAL_TRAP_EN
        tick(vec(0,0,0,0,0,0,0,0,0,2'd0), {nm, ".illegal"});
        tb_ill = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(vec(0,0,0,0,0,0,0,0,0,2'd0), {nm, ".halt"});
        reset = 1'b1;
        tick(12'h000, {nm, ".halt_rst"});
        reset = 1'b0;
        tb_ill = 1'b0; tb_ir = 16'h0000; tb_timeout = 1'b0;
`else
        tick(vec(0,0,0,0,0,0,0,0,1,2'd0), {nm, ".illegal_nop"});
`endif
      end
    endcase
  endtask

  initial begin
    reset = 1'b1; instr = 16'h0152; mem_ready = 1'b1; flags = 5'b0;
    @(posedge clk); #1;
    tick(12'h000, "reset0");
    tick(12'h000, "reset1");
    reset = 1'b0;

    run_instr("add",     16'h0152, 5'b00000, 0, 0);
    run_instr("load",    16'h4203, 5'b00000, 0, 3);
    run_instr("beq_t",   16'hC0F6, 5'b00010, 0, 0);
    run_instr("beq_f",   16'hC0F6, 5'b00000, 0, 0);
    run_instr("cmpi",    16'hB3A5, 5'b00000, 0, 0);
    run_instr("jmp_uc",  16'h4EC3, 5'b00000, 0, 0);
    run_instr("jne_f",   16'h41C3, 5'b00010, 0, 0);
    run_instr("bcs_t",   16'hC2F0, 5'b10000, 0, 0);
    run_instr("blo_t",   16'hCA10, 5'b01000, 0, 0);
    run_instr("bnv",     16'hC410, 5'b11111, 0, 0);
    run_instr("ill",     16'h7000, 5'b00000, 0, 0);
    run_instr("shift_r", 16'h8144, 5'b00000, 0, 0);
    run_instr("op8_i",   16'h8154, 5'b00000, 0, 0);
    run_instr("sub_r",   16'h0191, 5'b00000, 0, 0);
    run_instr("cmp_r",   16'h01B2, 5'b00000, 0, 0);
    run_instr("and_r",   16'h0112, 5'b00000, 0, 0);
    run_instr("movi",    16'hD1FF, 5'b00000, 0, 0);
    run_instr("store",   16'h4143, 5'b00000, 2, 1);
    run_instr("ill4",    16'h4183, 5'b00000, 0, 0);

    // Reset asserted while a load is waiting on memory.
    flags = 5'b0;
    do_fetch("midrst", 16'h4203, 0);
    mem_ready = 1'b1;
    tick(vec(0,0,0,0,0,0,0,0,0,2'd0), "midrst.decode");
    mem_ready = 1'b0;
    tick(vec(0,1,0,1,0,0,0,0,0,2'd0), "midrst.load");
    reset = 1'b1; mem_ready = 1'b1;
    tick(12'h000, "midrst.reset");
    reset = 1'b0; tb_ir = 16'h0000; mem_ready = 1'b0;
    tick(vec(0,1,0,0,0,0,0,0,0,2'd0), "midrst.after");
    run_instr("post_rst", 16'h0152, 5'b00000, 0, 0);

    run_instr("st_to",  16'h4143, 5'b00000, 0, 10);
    run_instr("ld_to",  16'h4203, 5'b00000, 0, 10);
    run_instr("f_to",   16'h0152, 5'b00000, 6, 0);

    reset = 1'b1; mem_ready = 1'b1;
    tick(12'h000, "final_rst0");
    tb_ir = 16'h0000; tb_timeout = 1'b0;
    tick(12'h000, "final_rst1");
    reset = 1'b0;
    run_instr("after_to", 16'h0152, 5'b00000, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
